scan_mux: RTL and testbench



---
 rtl/scan_mux.sv | 162 ++++++++++++++++
 tb/tb_scan_mux.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/scan_mux.sv
// N-channel registered mux with manual select or an enable-masked channel scan,
// presenting one sample at a time on a valid/ready output.
module scan_mux #(
    parameter int WIDTH = 8,
    parameter int CH    = 8,
    parameter int SW    = 3,
    parameter int DWELL = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CH*WIDTH-1:0]   din,
    input  logic                  mode,
    input  logic [SW-1:0]         sel_in,
    input  logic [CH-1:0]         ch_en,
    input  logic                  cont,
    input  logic                  start,
    input  logic                  y_ready,
    output logic [WIDTH-1:0]      y,
    output logic [SW-1:0]         y_ch,
    output logic                  y_valid,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(DWELL - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_EMIT} state_e;

    state_e           state_q, state_d;
    logic [CH-1:0]    en_q, en_d;
    logic [SW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [SW-1:0]    y_ch_q, y_ch_d;
    logic             y_valid_q, y_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] din_a [CH];
    logic             free, hs, sel_ok, nxt_found;
    logic [SW-1:0]    nxt_ptr;

    for (genvar g = 0; g < CH; g++) begin : g_din
        assign din_a[g] = din[g*WIDTH +: WIDTH];
    end

    function automatic logic [SW-1:0] lowest(input logic [CH-1:0] m);
        lowest = '0;
        for (int i = CH - 1; i >= 0; i--)
            if (m[i]) lowest = SW'(i);
    endfunction

    assign free   = !y_valid_q || y_ready;
    assign hs     = y_valid_q && y_ready;
    assign sel_ok = (int'(sel_in) < CH) && ch_en[sel_in];

    // Next enabled channel strictly above the current pointer in the latched mask.
    always_comb begin
        nxt_found = 1'b0;
        nxt_ptr   = '0;
        for (int i = CH - 1; i >= 0; i--) begin
            if (en_q[i] && (i > int'(ptr_q))) begin
                nxt_found = 1'b1;
                nxt_ptr   = SW'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        en_d      = en_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        y_d       = y_q;
        y_ch_d    = y_ch_q;
        y_valid_d = y_valid_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (start && mode && |ch_en) begin
                    en_d      = ch_en;
                    ptr_d     = lowest(ch_en);
                    cnt_d     = CNT_INIT;
                    busy_d    = 1'b1;
                    y_valid_d = 1'b0;
                    state_d   = ST_WAIT;
                end else if (!mode && free) begin
                    if (sel_ok) begin
                        y_d       = din_a[sel_in];
                        y_ch_d    = sel_in;
                        y_valid_d = 1'b1;
                    end else begin
                        y_valid_d = 1'b0;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    y_d       = din_a[ptr_q];
                    y_ch_d    = ptr_q;
                    y_valid_d = 1'b1;
                    state_d   = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (hs) begin
                    y_valid_d = 1'b0;
                    if (nxt_found) begin
                        ptr_d   = nxt_ptr;
                        cnt_d   = CNT_INIT;
                        state_d = ST_WAIT;
                    end else if (cont) begin
                        ptr_d   = lowest(en_q);
                        cnt_d   = CNT_INIT;
                        state_d = ST_WAIT;
                    end else begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            en_q      <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            y_q       <= '0;
            y_ch_q    <= '0;
            y_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            y_q       <= y_d;
            y_ch_q    <= y_ch_d;
            y_valid_q <= y_valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign y       = y_q;
    assign y_ch    = y_ch_q;
    assign y_valid = y_valid_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_scan_mux.sv
// Scoreboard bench for scan_mux: expected samples are queued at stimulus time
// and popped on each output handshake.
module tb_scan_mux;

    localparam int WIDTH = 8;
    localparam int CH    = 8;
    localparam int SW    = 3;
    localparam int DWELL = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [CH*WIDTH-1:0] din;
    logic                mode, cont, start, y_ready;
    logic [SW-1:0]       sel_in;
    logic [CH-1:0]       ch_en;
    logic [WIDTH-1:0]    y;
    logic [SW-1:0]       y_ch;
    logic                y_valid, busy, done;

    typedef struct {
        logic [2:0] ch;
        logic [7:0] data;
        int         gap;
    } exp_t;

    exp_t sb[$];
    int   nchk = 0, nfail = 0;
    int   cyc = 0, last_hs = 0, done_cnt = 0;
    logic mon_en = 1'b0;

    scan_mux #(.WIDTH(WIDTH), .CH(CH), .SW(SW), .DWELL(DWELL)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .mode(mode), .sel_in(sel_in),
        .ch_en(ch_en), .cont(cont), .start(start), .y_ready(y_ready),
        .y(y), .y_ch(y_ch), .y_valid(y_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int ch, input int gap);
        exp_t e;
        e.ch   = ch[2:0];
        e.data = 8'(8'h10 + ch);
        e.gap  = gap;
        sb.push_back(e);
    endtask

    task automatic kick();
        mode  = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_sweep(input int budget);
        int n = 0;
        while ((busy || sb.size() != 0) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk("sweep_in_time", 32'(n < budget), 1);
        @(posedge clk); #1;
    endtask

    // Handshake completes on the following rising edge.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (y_valid && y_ready) begin
                chk("sb_nonempty", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("hs_ch", y_ch, e.ch);
                    chk("hs_data", y, e.data);
                    if (e.gap != 0) chk("hs_gap", cyc + 1 - last_hs, e.gap);
                end
                last_hs = cyc + 1;
            end
            if (done) begin
                done_cnt++;
                chk("done_busy_low", busy, 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; mode = 1'b0; sel_in = '0; ch_en = 8'hFF;
        cont = 1'b0; start = 1'b0; y_ready = 1'b1;
        for (int i = 0; i < CH; i++) din[i*WIDTH +: WIDTH] = 8'(8'h10 + i);

        #3;
        chk("rst_y", y, 0); chk("rst_ych", y_ch, 0); chk("rst_vld", y_valid, 0);
        chk("rst_busy", busy, 0); chk("rst_done", done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // manual select, one-cycle latency
        for (int i = 0; i < CH; i++) begin
            sel_in = 3'(i);
            @(posedge clk); #1;
            chk("man_y", y, 8'h10 + i); chk("man_ch", y_ch, i); chk("man_vld", y_valid, 1);
        end
        sel_in = 3'd1;
        @(posedge clk); #1;
        chk("man_y1", y, 8'h11);
        y_ready = 1'b0; sel_in = 3'd4;
        @(posedge clk); #1;
        chk("man_hold_y", y, 8'h11); chk("man_hold_ch", y_ch, 1); chk("man_hold_vld", y_valid, 1);
        y_ready = 1'b1;
        @(posedge clk); #1;
        chk("man_y4", y, 8'h14);
        ch_en = 8'hF7; sel_in = 3'd3;
        @(posedge clk); #1;
        chk("man_dis_vld", y_valid, 0); chk("man_dis_y", y, 8'h14);

        // single sweep
        ch_en = 8'hA5; cont = 1'b0; done_cnt = 0;
        push(0, 0); push(2, DWELL + 1); push(5, DWELL + 1); push(7, DWELL + 1);
        kick();
        mon_en = 1'b1;
        chk("sw_busy", busy, 1); chk("sw_vld0", y_valid, 0);
        @(posedge clk); #1;
        chk("sw_vld1", y_valid, 0);
        @(posedge clk); #1;
        chk("sw_first_vld", y_valid, 1); chk("sw_first_y", y, 8'h10); chk("sw_first_ch", y_ch, 0);
        wait_sweep(60);
        chk("sw_done_cnt", done_cnt, 1); chk("sw_busy_end", busy, 0);

        // backpressure on ch2, din[5] disturbed while held
        done_cnt = 0;
        push(0, 0); push(2, 0); push(5, DWELL + 1); push(7, DWELL + 1);
        kick();
        begin
            int n = 0;
            while (!(y_valid && y_ch == 3'd2) && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            chk("bp_reach_ch2", 32'(n < 20), 1);
        end
        y_ready = 1'b0;
        din[5*WIDTH +: WIDTH] = 8'hEE;
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_hold_y", y, 8'h12); chk("bp_hold_ch", y_ch, 2); chk("bp_hold_vld", y_valid, 1);
        end
        din[5*WIDTH +: WIDTH] = 8'h15;
        y_ready = 1'b1;
        wait_sweep(60);
        chk("bp_done_cnt", done_cnt, 1);

        // continuous wrap; mask/mode changes mid-scan are ignored
        done_cnt = 0; ch_en = 8'h81; cont = 1'b1;
        push(0, 0);
        for (int i = 0; i < 5; i++) push((i % 2 == 0) ? 7 : 0, DWELL + 1);
        kick();
        ch_en = 8'hFF; mode = 1'b0;
        begin
            int n = 0;
            while (sb.size() > 2 && n < 60) begin
                @(posedge clk); #1;
                n++;
            end
            chk("cont_reach", 32'(n < 60), 1);
        end
        chk("cont_no_done", done_cnt, 0);
        cont = 1'b0; mode = 1'b1; ch_en = 8'h81;
        wait_sweep(60);
        chk("cont_done_cnt", done_cnt, 1);

        // start with empty mask is ignored
        ch_en = 8'h00;
        kick();
        repeat (3) begin
            @(posedge clk); #1;
            chk("empty_busy", busy, 0); chk("empty_vld", y_valid, 0);
        end

        // asynchronous reset while a sample is held in EMIT
        ch_en = 8'hA5; y_ready = 1'b0;
        kick();
        begin
            int n = 0;
            while (!y_valid && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            chk("emit_reach", 32'(n < 20), 1);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("arst_y", y, 0); chk("arst_ych", y_ch, 0); chk("arst_vld", y_valid, 0);
        chk("arst_busy", busy, 0); chk("arst_done", done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; y_ready = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            chk("post_rst_vld", y_valid, 0); chk("post_rst_busy", busy, 0);
        end

        // a fresh start works again
        ch_en = 8'h08; done_cnt = 0;
        push(3, 0);
        kick();
        wait_sweep(30);
        chk("restart_done", done_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
